// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary pointer conversion.
package async_fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;
    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Width-agnostic: callers zero-extend into ptr_t and truncate the result.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int unsigned i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// Multi-flop synchroniser for Gray-coded pointers; async active-low reset to 0.
module async_fifo_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock Gray-pointer FIFO with fill levels and watermarks per domain.
// Define ASYNC_FIFO_ERR_EN to add sticky woverflow/runderflow outputs.
module async_fifo_lvl
    import async_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic             wclk,
    input  logic             wrstn,
    input  logic             rclk,
    input  logic             rrstn,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic [AW:0]      wr_level,
    input  logic [AW:0]      af_thresh,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [AW:0]      rd_level,
    input  logic [AW:0]      ae_thresh
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic             woverflow,
    output logic             runderflow
`endif
);

    typedef logic [AW:0] aptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];

    aptr_t            wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d, rq_gray;
    logic             wfull_q, wfull_d, wacc;
    aptr_t            rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d, wq_gray;
    logic             rempty_q, rempty_d, racc;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    async_fifo_sync #(.WIDTH(AW + 1), .STAGES(SYNC_STAGES)) u_r2w (
        .clk_i (wclk),
        .rstn_i(wrstn),
        .d_i   (rgray_q),
        .q_o   (rq_gray)
    );

    async_fifo_sync #(.WIDTH(AW + 1), .STAGES(SYNC_STAGES)) u_w2r (
        .clk_i (rclk),
        .rstn_i(rrstn),
        .d_i   (wgray_q),
        .q_o   (wq_gray)
    );

    always_comb begin
        wacc     = winc && !wfull_q;
        wbin_d   = wbin_q + aptr_t'(wacc);
        wgray_d  = aptr_t'(bin2gray(ptr_t'(wbin_d)));
        wfull_d  = (wgray_d == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
        wlevel_d = wbin_d - aptr_t'(gray2bin(ptr_t'(rq_gray)));
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wacc) begin
            mem_q[wbin_q[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        racc     = rinc && !rempty_q;
        rbin_d   = rbin_q + aptr_t'(racc);
        rgray_d  = aptr_t'(bin2gray(ptr_t'(rbin_d)));
        rempty_d = (rgray_d == wq_gray);
        rlevel_d = aptr_t'(gray2bin(ptr_t'(wq_gray))) - rbin_d;
        rdata_d  = racc ? mem_q[rbin_q[AW-1:0]] : rdata_q;
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
            rdata_q  <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rempty_q <= rempty_d;
            rlevel_q <= rlevel_d;
            rdata_q  <= rdata_d;
        end
    end

    // Watermarks compare the registered level against quasi-static thresholds,
    // which also yields the threshold-dependent reset value without an async load.
    assign walmost_full  = (wlevel_q >= af_thresh);
    assign ralmost_empty = (rlevel_q <= ae_thresh);
    assign wfull         = wfull_q;
    assign wr_level      = wlevel_q;
    assign rempty        = rempty_q;
    assign rd_level      = rlevel_q;
    assign rdata         = rdata_q;

`ifdef ASYNC_FIFO_ERR_EN
    logic wovf_q, rund_q;

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wovf_q <= 1'b0;
        end else if (winc && wfull_q) begin
            wovf_q <= 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rund_q <= 1'b0;
        end else if (rinc && rempty_q) begin
            rund_q <= 1'b1;
        end
    end

    assign woverflow  = wovf_q;
    assign runderflow = rund_q;
`endif

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed + randomized bench for async_fifo_lvl against a queue-based model.
module tb_async_fifo_lvl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned ITEMS = 1000;

    logic       wclk = 1'b0, rclk = 1'b0;
    logic       wrstn, rrstn, winc, rinc;
    logic [7:0] wdata, rdata;
    logic       wfull, walmost_full, rempty, ralmost_empty;
    logic [4:0] wr_level, rd_level, af_thresh, ae_thresh;
`ifdef ASYNC_FIFO_ERR_EN
    logic       woverflow, runderflow;
`endif

    int unsigned whalf = 10, rhalf = 17;
    int unsigned n_assert = 0, n_fail = 0;
    logic [7:0]  model_q [$];
    logic [7:0]  exp_d;
    logic        w_acc, r_acc;
    int unsigned wn, rn, wguard, rguard, lat;

    always #(whalf) wclk = ~wclk;
    always #(rhalf) rclk = ~rclk;

    async_fifo_lvl #(.DEPTH(DEPTH), .WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .wclk         (wclk),
        .wrstn        (wrstn),
        .rclk         (rclk),
        .rrstn        (rrstn),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wr_level     (wr_level),
        .af_thresh    (af_thresh),
        .rinc         (rinc),
        .rdata        (rdata),
        .rempty       (rempty),
        .ralmost_empty(ralmost_empty),
        .rd_level     (rd_level),
        .ae_thresh    (ae_thresh)
`ifdef ASYNC_FIFO_ERR_EN
        ,
        .woverflow    (woverflow),
        .runderflow   (runderflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_one(input logic [7:0] d);
        @(negedge wclk); winc = 1'b1; wdata = d;
        @(negedge wclk); winc = 1'b0;
    endtask

    task automatic rd_one();
        @(negedge rclk); rinc = 1'b1;
        @(negedge rclk); rinc = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rempty"}, 32'(rempty), 32'd1);
        check({tag, "_wfull"}, 32'(wfull), 32'd0);
        check({tag, "_wr_level"}, 32'(wr_level), 32'd0);
        check({tag, "_rd_level"}, 32'(rd_level), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_walmost_full"}, 32'(walmost_full), 32'(af_thresh == 5'd0));
        check({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wrstn = 1'b0; rrstn = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        af_thresh = 5'd12; ae_thresh = 5'd3;
        repeat (3) @(posedge rclk);
        #1;
        check_reset_values("reset");
        @(negedge wclk); wrstn = 1'b1; rrstn = 1'b1;
        repeat (2) @(posedge rclk);

        // Fill with no reads: the write side sees the exact level.
        for (int i = 0; i < 16; i++) begin
            wr_one(8'(i));
            check("fill_wr_level", 32'(wr_level), 32'(i + 1));
            check("fill_walmost_full", 32'(walmost_full), 32'(i + 1 >= 12));
            check("fill_wfull", 32'(wfull), 32'(i + 1 == 16));
            if (i == 11) begin
                repeat (SYNC + 3) @(posedge rclk);
                #1;
                check("wm_rd_level", 32'(rd_level), 32'd12);
                check("wm_ralmost_empty", 32'(ralmost_empty), 32'd0);
                check("wm_rempty", 32'(rempty), 32'd0);
            end
        end
        wr_one(8'hEE);
        check("ovf_wr_level", 32'(wr_level), 32'd16);
        check("ovf_wfull", 32'(wfull), 32'd1);
`ifdef ASYNC_FIFO_ERR_EN
        check("woverflow", 32'(woverflow), 32'd1);
`endif
        repeat (SYNC + 3) @(posedge rclk);
        #1;
        check("full_rd_level", 32'(rd_level), 32'd16);

        // Drain with no writes: the read side sees the exact level.
        for (int i = 1; i <= 16; i++) begin
            rd_one();
            check("drain_rdata", 32'(rdata), 32'(i - 1));
            check("drain_rd_level", 32'(rd_level), 32'(16 - i));
            check("drain_ralmost_empty", 32'(ralmost_empty), 32'(16 - i <= 3));
            check("drain_rempty", 32'(rempty), 32'(i == 16));
        end
        rd_one();
        check("udf_rdata_hold", 32'(rdata), 32'h0F);
        check("udf_rd_level", 32'(rd_level), 32'd0);
`ifdef ASYNC_FIFO_ERR_EN
        check("runderflow", 32'(runderflow), 32'd1);
`endif
        repeat (SYNC + 3) @(posedge wclk);
        #1;
        check("drained_wr_level", 32'(wr_level), 32'd0);
        check("drained_wfull", 32'(wfull), 32'd0);
        check("drained_walmost_full", 32'(walmost_full), 32'd0);

        // Mid-operation reset with 8 entries held.
        for (int i = 0; i < 8; i++) wr_one(8'(8'h40 + i));
        check("mid_wr_level", 32'(wr_level), 32'd8);
        @(negedge wclk); wrstn = 1'b0; rrstn = 1'b0;
        #1;
        check_reset_values("midrst");
`ifdef ASYNC_FIFO_ERR_EN
        check("midrst_woverflow", 32'(woverflow), 32'd0);
        check("midrst_runderflow", 32'(runderflow), 32'd0);
`endif
        repeat (3) @(posedge rclk);
        @(negedge wclk); wrstn = 1'b1; rrstn = 1'b1;
        repeat (2) @(posedge rclk);

        @(negedge wclk); winc = 1'b1; wdata = 8'hA5;
        @(posedge wclk); #1; winc = 1'b0;
        lat = 0;
        while (rempty && lat < SYNC + 1) begin
            @(posedge rclk); #1;
            lat++;
        end
        check("rempty_latency", 32'(rempty), 32'd0);
        rd_one();
        check("a5_rdata", 32'(rdata), 32'hA5);
        check("a5_rempty", 32'(rempty), 32'd1);

        // Randomized stress with swapped clock periods.
        wrstn = 1'b0; rrstn = 1'b0;
        whalf = 17; rhalf = 10;
        repeat (4) @(posedge wclk);
        @(negedge wclk); wrstn = 1'b1; rrstn = 1'b1;
        repeat (2) @(posedge wclk);
        model_q.delete();
        wn = 0; rn = 0; wguard = 0; rguard = 0;
        fork
            begin
                while (wn < ITEMS && wguard < 4000) begin
                    @(negedge wclk);
                    winc  = ($urandom_range(99) < 70);
                    wdata = 8'($urandom);
                    w_acc = winc && !wfull;
                    @(posedge wclk);
                    if (w_acc) begin
                        model_q.push_back(wdata);
                        wn++;
                    end
                    #1;
                    check("st_wr_level_max", 32'(wr_level <= 5'd16), 32'd1);
                    check("st_wr_level_ge_held", 32'(32'(wr_level) >= model_q.size()), 32'd1);
                    if (model_q.size() == DEPTH) check("st_wfull_held", 32'(wfull), 32'd1);
                    wguard++;
                end
                @(negedge wclk); winc = 1'b0;
            end
            begin
                while (rn < ITEMS && rguard < 10000) begin
                    @(negedge rclk);
                    rinc  = ($urandom_range(99) < 70);
                    r_acc = rinc && !rempty;
                    @(posedge rclk);
                    if (r_acc) begin
                        check("st_rd_has_data", 32'(model_q.size() != 0), 32'd1);
                        exp_d = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
                        rn++;
                    end
                    #1;
                    if (r_acc) check("st_rdata", 32'(rdata), 32'(exp_d));
                    check("st_rd_level_max", 32'(rd_level <= 5'd16), 32'd1);
                    check("st_rd_level_le_held", 32'(32'(rd_level) <= model_q.size()), 32'd1);
                    if (model_q.size() == 0) check("st_rempty_none", 32'(rempty), 32'd1);
                    rguard++;
                end
                @(negedge rclk); rinc = 1'b0;
            end
        join
        check("st_items_written", wn, ITEMS);
        check("st_items_read", rn, ITEMS);
        repeat (SYNC + 4) @(posedge wclk);
        #1;
        check("st_end_wr_level", 32'(wr_level), 32'd0);
        check("st_end_rd_level", 32'(rd_level), 32'd0);
        check("st_end_rempty", 32'(rempty), 32'd1);
        check("st_end_wfull", 32'(wfull), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
